lvds_rx_deser: RTL and testbench



---
 rtl/lvds_rx_pkg.sv | 21 ++
 rtl/lvds_rx_front.sv | 54 +++++
 rtl/lvds_rx_deser.sv | 146 ++++++++++++++
 tb/tb_lvds_rx_deser.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_rx_pkg.sv
// Shared types and helpers for the LVDS receive deserializer.
//   rx_state_t  : framing state (HUNT, VERIFY, LOCK)
//   SYNC_STAGES : depth of the input synchronizer on each leg
//   clog2()     : counter width helper, never returns less than 1
package lvds_rx_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } rx_state_t;

    localparam int SYNC_STAGES = 2;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/lvds_rx_front.sv
// Input front end: two-flop synchronizer on each leg of the differential
// pair followed by the differential decode.
//   CLK, RST : clock, synchronous active-high reset
//   IP, IN   : differential pair (true / complement leg)
//   rx_bit   : decoded bit (combinational off the last sync stage)
//   derr     : registered one-cycle flag for an invalid sample
module lvds_rx_front
    import lvds_rx_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic IP,
    input  logic IN,
    output logic rx_bit,
    output logic derr
);

    logic [SYNC_STAGES-1:0] ip_sync;
    logic [SYNC_STAGES-1:0] in_sync;
    logic                   last_bit;
    logic                   pair_ok;
    logic                   ip_s;
    logic                   in_s;

    assign ip_s = ip_sync[SYNC_STAGES-1];
    assign in_s = in_sync[SYNC_STAGES-1];

    // Only the two complementary combinations are legal; equal legs or an
    // unknown level on either leg falls through to the invalid case.
    always_comb begin
        pair_ok = 1'b0;
        if ((ip_s === 1'b1) && (in_s === 1'b0)) pair_ok = 1'b1;
        if ((ip_s === 1'b0) && (in_s === 1'b1)) pair_ok = 1'b1;
    end

    assign rx_bit = pair_ok ? ip_s : last_bit;

    // The sync stages reset to a legal "0" pair so that flushing them after
    // reset does not raise a spurious decode error.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ip_sync  <= '0;
            in_sync  <= '1;
            last_bit <= 1'b0;
            derr     <= 1'b0;
        end else begin
            ip_sync  <= {ip_sync[SYNC_STAGES-2:0], IP};
            in_sync  <= {in_sync[SYNC_STAGES-2:0], IN};
            last_bit <= rx_bit;
            derr     <= ~pair_ok;
        end
    end

endmodule

// File: rtl/lvds_rx_deser.sv
// LVDS receive deserializer: decodes the differential pair, shifts bits into
// WIDTH-bit words (MSB first on the wire), aligns on SYNC_WORD and presents
// framed words with a one-cycle valid strobe.
//   CLK, RST : clock, synchronous active-high reset
//   IP, IN   : differential pair
//   DO       : received word, held between strobes
//   DV       : one-cycle strobe, DO valid
//   ISSYNC   : with DV, DO equals SYNC_WORD
//   LOCKED   : high while word alignment is locked
//   DERR     : one-cycle pulse on an invalid differential sample
//
//   state  | meaning
//   HUNT   | sliding compare against SYNC_WORD at every bit offset
//   VERIFY | boundary chosen; counting consecutive sync words at it
//   LOCK   | emitting words; timeout counter watches for lost sync
module lvds_rx_deser
    import lvds_rx_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD  = WIDTH'(8'hA5),
    parameter int               VERIFY_CNT = 2,
    parameter int               TIMEOUT    = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IP,
    input  logic             IN,
    output logic [WIDTH-1:0] DO,
    output logic             DV,
    output logic             ISSYNC,
    output logic             LOCKED,
    output logic             DERR
);

    localparam int PH_W = clog2(WIDTH);
    localparam int VC_W = clog2(VERIFY_CNT + 1);
    localparam int TO_W = clog2(TIMEOUT + 1);

    logic             rx_bit;
    rx_state_t        state, state_nxt;
    logic [PH_W-1:0]  phase, phase_nxt;
    logic [VC_W-1:0]  cnt, cnt_nxt;
    logic [TO_W-1:0]  wcnt, wcnt_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [WIDTH-1:0] do_nxt;
    logic             dv_nxt;
    logic             issync_nxt;
    logic             word_done;
    logic             is_sync;

    lvds_rx_front u_front (
        .CLK    (CLK),
        .RST    (RST),
        .IP     (IP),
        .IN     (IN),
        .rx_bit (rx_bit),
        .derr   (DERR)
    );

    // shreg and phase are registered, so the decisions below act on the
    // word that finished shifting in on the previous edge.
    assign word_done = (phase == PH_W'(WIDTH - 1));
    assign is_sync   = (shreg == SYNC_WORD);
    assign LOCKED    = (state == LOCK);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            phase  <= '0;
            cnt    <= '0;
            wcnt   <= '0;
            shreg  <= '0;
            DO     <= '0;
            DV     <= 1'b0;
            ISSYNC <= 1'b0;
        end else begin
            phase  <= phase_nxt;
            cnt    <= cnt_nxt;
            wcnt   <= wcnt_nxt;
            shreg  <= shreg_nxt;
            DO     <= do_nxt;
            DV     <= dv_nxt;
            ISSYNC <= issync_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        phase_nxt  = word_done ? '0 : phase + PH_W'(1);
        cnt_nxt    = cnt;
        wcnt_nxt   = wcnt;
        shreg_nxt  = {shreg[WIDTH-2:0], rx_bit};
        do_nxt     = DO;
        dv_nxt     = 1'b0;
        issync_nxt = 1'b0;

        case (state)
            HUNT: begin
                if (is_sync) begin
                    // The bit entering on this edge is the first of the next word.
                    phase_nxt = '0;
                    cnt_nxt   = VC_W'(1);
                    wcnt_nxt  = '0;
                    state_nxt = (VERIFY_CNT == 1) ? LOCK : VERIFY;
                end
            end
            VERIFY: begin
                if (word_done) begin
                    if (!is_sync) begin
                        state_nxt = HUNT;
                    end else if (cnt == VC_W'(VERIFY_CNT - 1)) begin
                        state_nxt = LOCK;
                        wcnt_nxt  = '0;
                    end else begin
                        cnt_nxt = cnt + VC_W'(1);
                    end
                end
            end
            LOCK: begin
                if (word_done) begin
                    do_nxt     = shreg;
                    dv_nxt     = 1'b1;
                    issync_nxt = is_sync;
                    // A sync word on the timeout word still keeps lock.
                    if (is_sync) begin
                        wcnt_nxt = '0;
                    end else if (wcnt == TO_W'(TIMEOUT - 1)) begin
                        wcnt_nxt  = '0;
                        state_nxt = HUNT;
                    end else begin
                        wcnt_nxt = wcnt + TO_W'(1);
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

endmodule

// File: tb/tb_lvds_rx_deser.sv
module tb_lvds_rx_deser;

    localparam int          W    = 8;
    localparam logic [W-1:0] SYNC = 8'hA5;
    localparam int          VC   = 2;
    localparam int          TO   = 8;
    localparam int          RING = 1024;

    localparam int M_SEARCH  = 0;
    localparam int M_CONFIRM = 1;
    localparam int M_FRAMED  = 2;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         IP  = 1'b0;
    logic         IN  = 1'b1;
    logic [W-1:0] DO;
    logic         DV, ISSYNC, LOCKED, DERR;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;
    int dv_seen = 0;
    int derr_seen = 0;

    // expected events keyed by the rising edge at which they become visible
    bit           ev_dv   [RING];
    logic [W-1:0] ev_do   [RING];
    bit           ev_sync [RING];
    bit           ev_lkv  [RING];
    bit           ev_lk   [RING];
    bit           ev_derr [RING];
    logic [W-1:0] cur_do;
    bit           cur_locked;

    // reference model: bit-stream framing
    int           m_mode;
    int           m_bits, m_seen, m_miss;
    bit           m_last;
    logic [W-1:0] m_win;

    lvds_rx_deser #(
        .WIDTH(W), .SYNC_WORD(SYNC), .VERIFY_CNT(VC), .TIMEOUT(TO)
    ) dut (
        .CLK(CLK), .RST(RST), .IP(IP), .IN(IN),
        .DO(DO), .DV(DV), .ISSYNC(ISSYNC), .LOCKED(LOCKED), .DERR(DERR)
    );

    always #5 CLK = ~CLK;

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @edge %0d: got %b expected %b", tag, edge_n, obs, exp);
        end
    endtask

    task automatic checkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @edge %0d: got %h expected %h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s @edge %0d: got %0d expected %0d", tag, edge_n, obs, exp);
        end
    endtask

    function automatic int slot(input int ofs);
        return (edge_n + ofs) % RING;
    endfunction

    task automatic sched_lock(input bit v);
        ev_lkv[slot(3)] = 1'b1;
        ev_lk[slot(3)]  = v;
    endtask

    // Called for the bit sampled at edge edge_n.
    task automatic model_bit(input logic ip, input logic inn);
        bit ok, b;
        ok = (ip != inn);
        b  = ok ? ip : m_last;
        m_last = b;
        ev_derr[slot(2)] = !ok;
        m_win = {m_win[W-2:0], b};
        if (m_mode == M_SEARCH) begin
            if (m_win == SYNC) begin
                m_bits = 0;
                m_seen = 1;
                m_miss = 0;
                if (VC == 1) begin
                    m_mode = M_FRAMED;
                    sched_lock(1'b1);
                end else begin
                    m_mode = M_CONFIRM;
                end
            end
        end else begin
            m_bits++;
            if (m_bits == W) begin
                m_bits = 0;
                if (m_mode == M_CONFIRM) begin
                    if (m_win != SYNC) begin
                        m_mode = M_SEARCH;
                    end else begin
                        m_seen++;
                        if (m_seen == VC) begin
                            m_mode = M_FRAMED;
                            m_miss = 0;
                            sched_lock(1'b1);
                        end
                    end
                end else begin
                    ev_dv[slot(3)]   = 1'b1;
                    ev_do[slot(3)]   = m_win;
                    ev_sync[slot(3)] = (m_win == SYNC);
                    if (m_win == SYNC) begin
                        m_miss = 0;
                    end else begin
                        m_miss++;
                        if (m_miss == TO) begin
                            m_mode = M_SEARCH;
                            sched_lock(1'b0);
                        end
                    end
                end
            end
        end
    endtask

    task automatic clear_slot(input int s);
        ev_dv[s] = 1'b0; ev_sync[s] = 1'b0; ev_lkv[s] = 1'b0;
        ev_lk[s] = 1'b0; ev_derr[s] = 1'b0;
    endtask

    task automatic tick(input logic ip, input logic inn, input logic rst);
        int s;
        IP = ip; IN = inn; RST = rst;
        if (!rst) model_bit(ip, inn);
        @(posedge CLK);
        #1;
        s = slot(0);
        if (rst) begin
            for (int i = 0; i < 4; i++) clear_slot(slot(i));
            m_mode = M_SEARCH; m_bits = 0; m_seen = 0; m_miss = 0;
            m_last = 1'b0; m_win = '0;
            cur_do = '0; cur_locked = 1'b0;
            check1("rst_dv", DV, 1'b0);
            checkw("rst_do", DO, '0);
            check1("rst_issync", ISSYNC, 1'b0);
            check1("rst_locked", LOCKED, 1'b0);
            check1("rst_derr", DERR, 1'b0);
        end else begin
            if (ev_dv[s]) cur_do = ev_do[s];
            if (ev_lkv[s]) cur_locked = ev_lk[s];
            check1("dv", DV, ev_dv[s]);
            checkw("do", DO, cur_do);
            check1("locked", LOCKED, cur_locked);
            check1("derr", DERR, ev_derr[s]);
            if (ev_dv[s]) check1("issync", ISSYNC, ev_sync[s]);
            clear_slot(s);
        end
        if (DV === 1'b1) dv_seen++;
        if (DERR === 1'b1) derr_seen++;
        edge_n++;
    endtask

    task automatic send_bit(input logic b);
        tick(b, ~b, 1'b0);
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        logic [W-1:0] w;
        logic b;

        do_reset();
        do_reset();

        // lock on two sync words, first framed word 0x3C
        dv_seen = 0;
        send_word(SYNC); send_word(SYNC); send_word(8'h3C);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        checkw("t1_do", DO, 8'h3C);
        check1("t1_locked", LOCKED, 1'b1);
        checki("t1_dv_count", dv_seen, 1);
        for (int i = 0; i < 5; i++) send_bit(1'b0);

        // lock at a 3-bit offset
        do_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_word(SYNC); send_word(SYNC); send_word(8'h11); send_word(SYNC);
        send_word(8'h00);

        // timeout after 8 non-sync words, then a failed relock attempt
        do_reset();
        send_word(SYNC); send_word(SYNC);
        dv_seen = 0;
        for (int i = 1; i <= TO; i++) send_word(W'(i));
        send_word(SYNC); send_word(8'h42); send_word(8'h00);
        check1("t3_locked", LOCKED, 1'b0);
        checki("t3_dv_count", dv_seen, TO);

        // invalid sample mid-word while locked
        do_reset();
        send_word(SYNC); send_word(SYNC);
        derr_seen = 0;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        tick(1'b1, 1'b1, 1'b0);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        checkw("t4_do", DO, 8'hF8);
        check1("t4_locked", LOCKED, 1'b1);
        checki("t4_derr_count", derr_seen, 1);
        send_word(SYNC);

        // sync followed by a near-miss in verify
        do_reset();
        dv_seen = 0;
        send_word(SYNC); send_word(8'hA4); send_word(8'h00); send_word(8'h00);
        check1("t5_locked", LOCKED, 1'b0);
        checki("t5_dv_count", dv_seen, 0);

        // reset mid-word while locked, then relock
        do_reset();
        send_word(SYNC); send_word(SYNC); send_word(8'h3C);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        do_reset();
        dv_seen = 0;
        send_word(SYNC); send_word(8'h3C);
        checki("t6_no_dv", dv_seen, 0);
        send_word(SYNC); send_word(SYNC); send_word(8'h3C);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        check1("t6_locked", LOCKED, 1'b1);
        checkw("t6_do", DO, 8'h3C);
        for (int i = 0; i < 5; i++) send_bit(1'b0);

        // randomized stream: sync words, slips, invalid samples, rare resets
        for (int n = 0; n < 200; n++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r < 6) begin
                send_word(SYNC);
            end else if (r < 8) begin
                for (int i = 0; i < int'($urandom_range(1, 3)); i++) send_bit(1'($urandom));
            end else if (r == 8) begin
                do_reset();
            end else begin
                w = W'($urandom);
                for (int i = W - 1; i >= 0; i--) begin
                    if ($urandom_range(0, 39) == 0) begin
                        b = 1'($urandom);
                        tick(b, b, 1'b0);
                    end else begin
                        send_bit(w[i]);
                    end
                end
            end
        end
        for (int i = 0; i < 4; i++) send_bit(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
